// File: rtl/mux_stim_gen.sv
// Clocked stimulus generator for an N-to-1 mux under test: sweeps the select
// through fixed data patterns and publishes the expected output with a strobe.
// Define MUX_STIM_RANDOM_EN to add a fifth, LFSR-driven step per channel.
module mux_stim_gen #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned HOLD     = 10,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      abort_i,
    output logic [CHANNELS*WIDTH-1:0] data_o,
    output logic [SEL_W-1:0]          sel_o,
    output logic [WIDTH-1:0]          expected_o,
    output logic                      valid_o,
    output logic                      busy_o,
    output logic                      done_o
);

`ifdef MUX_STIM_RANDOM_EN
    localparam int unsigned NSTEP = 5;
`else
    localparam int unsigned NSTEP = 4;
`endif
    localparam int unsigned      HW     = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0]    H_LAST = HW'(HOLD - 1);
    localparam logic [SEL_W-1:0] C_LAST = SEL_W'(CHANNELS - 1);
    localparam logic [2:0]       S_LAST = 3'(NSTEP - 1);
    localparam logic [WIDTH-1:0] PAT    = WIDTH'({WIDTH{2'b01}});

    // A zero seed would lock the LFSR at zero.
    if (CHANNELS < 2 || (2 ** SEL_W) < CHANNELS || HOLD < 1 || SEED == 16'h0) begin : g_param_check
        $error("mux_stim_gen: invalid parameter set");
    end

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t                    st_q, st_d;
    logic [SEL_W-1:0]          c_q, c_d;
    logic [2:0]                s_q, s_d;
    logic [HW-1:0]             h_q, h_d;
    logic [CHANNELS*WIDTH-1:0] data_q, data_d;
    logic [SEL_W-1:0]          sel_q, sel_d;
    logic [WIDTH-1:0]          exp_q, exp_d;
    logic                      valid_q, valid_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [WIDTH-1:0]          lane_sel, lane_oth;
`ifdef MUX_STIM_RANDOM_EN
    logic [15:0]               lfsr_q, lfsr_d;
    logic [WIDTH-1:0]          rnd;
`endif

    always_comb begin
        st_d     = st_q;
        c_d      = c_q;
        s_d      = s_q;
        h_d      = h_q;
        lane_sel = '0;
        lane_oth = '0;
        data_d   = '0;
        sel_d    = '0;
        exp_d    = '0;
        valid_d  = 1'b0;
        busy_d   = 1'b0;
`ifdef MUX_STIM_RANDOM_EN
        lfsr_d   = lfsr_q;
        rnd      = '0;
`endif
        case (st_q)
            IDLE: begin
                if (start_i && !abort_i) begin
                    st_d = RUN;
                    c_d  = '0;
                    s_d  = '0;
                    h_d  = '0;
                end
            end
            RUN: begin
                if (abort_i) begin
                    st_d = IDLE;
                    c_d  = '0;
                    s_d  = '0;
                    h_d  = '0;
                end else if (h_q == H_LAST) begin
                    h_d = '0;
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        if (c_q == C_LAST) begin
                            st_d = FIN;
                            c_d  = '0;
                        end else begin
                            c_d = c_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 3'd1;
                    end
                end else begin
                    h_d = h_q + 1'b1;
                end
            end
            FIN:     st_d = IDLE;
            default: st_d = IDLE;
        endcase

        // Outputs are computed from the next state so they register in step.
        if (st_d == RUN) begin
`ifdef MUX_STIM_RANDOM_EN
            if (s_d == 3'd4 && h_d == '0)
                lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            rnd = WIDTH'({{WIDTH{1'b0}}, lfsr_d});
`endif
            case (s_d)
                3'd0:    begin lane_sel = '0;   lane_oth = '1;   end
                3'd1:    begin lane_sel = '1;   lane_oth = '0;   end
                3'd2:    begin lane_sel = PAT;  lane_oth = ~PAT; end
                3'd3:    begin lane_sel = ~PAT; lane_oth = PAT;  end
                default: begin lane_sel = '0;   lane_oth = '0;   end
            endcase
            for (int unsigned l = 0; l < CHANNELS; l++)
                data_d[l*WIDTH +: WIDTH] = (SEL_W'(l) == c_d) ? lane_sel : lane_oth;
            exp_d = lane_sel;
`ifdef MUX_STIM_RANDOM_EN
            if (s_d == 3'd4) begin
                for (int unsigned l = 0; l < CHANNELS; l++)
                    data_d[l*WIDTH +: WIDTH] = rnd ^ WIDTH'(l);
                exp_d = rnd ^ WIDTH'(c_d);
            end
`endif
            sel_d   = c_d;
            valid_d = (h_d == H_LAST);
            busy_d  = 1'b1;
        end
        done_d = (st_d == FIN);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st_q    <= IDLE;
            c_q     <= '0;
            s_q     <= '0;
            h_q     <= '0;
            data_q  <= '0;
            sel_q   <= '0;
            exp_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MUX_STIM_RANDOM_EN
            lfsr_q  <= SEED;
`endif
        end else begin
            st_q    <= st_d;
            c_q     <= c_d;
            s_q     <= s_d;
            h_q     <= h_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            exp_q   <= exp_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MUX_STIM_RANDOM_EN
            lfsr_q  <= lfsr_d;
`endif
        end
    end

    assign data_o     = data_q;
    assign sel_o      = sel_q;
    assign expected_o = exp_q;
    assign valid_o    = valid_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_mux_stim_gen.sv
// Bench for mux_stim_gen: two configurations checked cycle by cycle against a
// sweep table built from the pattern rules; honours MUX_STIM_RANDOM_EN.
module tb_mux_stim_gen;

`ifdef MUX_STIM_RANDOM_EN
    localparam int NS = 5;
`else
    localparam int NS = 4;
`endif

    typedef struct {
        logic [31:0] data;
        logic [1:0]  sel;
        logic [7:0]  exp;
        bit          valid;
        int          step;
        logic [15:0] lf;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_start = 1'b0, a_abort = 1'b0, b_start = 1'b0, b_abort = 1'b0;
    logic [3:0]  a_data;
    logic [1:0]  a_sel;
    logic [0:0]  a_exp;
    logic        a_valid, a_busy, a_done;
    logic [23:0] b_data;
    logic [1:0]  b_sel;
    logic [7:0]  b_exp;
    logic        b_valid, b_busy, b_done;

    logic [31:0] o_data;
    logic [1:0]  o_sel;
    logic [7:0]  o_exp;
    logic        o_valid, o_busy, o_done;

    int          checks = 0;
    int          errors = 0;
    bit          use_b = 1'b0;
    int          cw = 1, cc = 4, ch = 10;
    logic [15:0] model_lf [2];
    ent_t        q[$];
    logic [31:0] cap_data[$];
    logic [7:0]  cap_exp[$];
    logic [1:0]  cap_sel[$];
    bit          cap_valid[$];
    int          nvalid, nbusy;

    always #5 clk = ~clk;

    mux_stim_gen #(.WIDTH(1), .CHANNELS(4), .SEL_W(2), .HOLD(10)) u_a (
        .clk_i(clk), .rst_i(rst), .start_i(a_start), .abort_i(a_abort),
        .data_o(a_data), .sel_o(a_sel), .expected_o(a_exp),
        .valid_o(a_valid), .busy_o(a_busy), .done_o(a_done)
    );

    mux_stim_gen #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .HOLD(1)) u_b (
        .clk_i(clk), .rst_i(rst), .start_i(b_start), .abort_i(b_abort),
        .data_o(b_data), .sel_o(b_sel), .expected_o(b_exp),
        .valid_o(b_valid), .busy_o(b_busy), .done_o(b_done)
    );

    always_comb begin
        o_data  = use_b ? {8'h0, b_data} : {28'h0, a_data};
        o_sel   = use_b ? b_sel : a_sel;
        o_exp   = use_b ? b_exp : {7'h0, a_exp};
        o_valid = use_b ? b_valid : a_valid;
        o_busy  = use_b ? b_busy : a_busy;
        o_done  = use_b ? b_done : a_done;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] lfsr_next(logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    function automatic logic [7:0] lane_val(int w, int c, int s, int l, logic [15:0] lf);
        logic [7:0] ones, pat;
        bit         me;
        ones = 8'((1 << w) - 1);
        pat  = '0;
        for (int i = 0; i < w; i += 2) pat[i] = 1'b1;
        me = (l == c);
        case (s)
            0:       return me ? 8'h0 : ones;
            1:       return me ? ones : 8'h0;
            2:       return me ? pat : (~pat & ones);
            3:       return me ? (~pat & ones) : pat;
            default: return (lf[7:0] ^ 8'(l)) & ones;
        endcase
    endfunction

    task automatic pick(input bit b);
        use_b = b;
        cw = b ? 8 : 1;
        cc = b ? 3 : 4;
        ch = b ? 1 : 10;
    endtask

    task automatic drive(input bit st, input bit ab);
        a_start = use_b ? 1'b0 : st;
        a_abort = use_b ? 1'b0 : ab;
        b_start = use_b ? st : 1'b0;
        b_abort = use_b ? ab : 1'b0;
    endtask

    task automatic build_exp();
        ent_t        e;
        logic [15:0] lf;
        q.delete();
        lf = model_lf[use_b];
        for (int c = 0; c < cc; c++)
            for (int s = 0; s < NS; s++)
                for (int h = 0; h < ch; h++) begin
                    if (s == 4 && h == 0) lf = lfsr_next(lf);
                    e.data = '0;
                    for (int l = 0; l < cc; l++)
                        e.data = e.data | (32'(lane_val(cw, c, s, l, lf)) << (l * cw));
                    e.sel   = 2'(c);
                    e.exp   = lane_val(cw, c, s, c, lf);
                    e.valid = (h == ch - 1);
                    e.step  = s;
                    e.lf    = lf;
                    q.push_back(e);
                end
    endtask

    // Called at a negedge with the selected DUT idle; returns at a negedge, idle.
    task automatic run_sweep(input int abort_k, input bit noise);
        ent_t e;
        build_exp();
        cap_data.delete(); cap_exp.delete(); cap_sel.delete(); cap_valid.delete();
        nvalid = 0;
        nbusy  = 0;
        drive(1'b1, 1'b0);
        @(negedge clk);
        for (int k = 0; k < q.size(); k++) begin
            e = q[k];
            cap_data.push_back(o_data);
            cap_exp.push_back(o_exp);
            cap_sel.push_back(o_sel);
            cap_valid.push_back(o_valid);
            if (o_valid) nvalid++;
            if (o_busy)  nbusy++;
            checks++;
            if ({o_data, o_sel, o_exp, o_valid, o_busy, o_done} !==
                {e.data, e.sel, e.exp, e.valid, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL sweep dut=%0d cyc=%0d: data=%h sel=%0d exp=%h valid=%b busy=%b done=%b, want data=%h sel=%0d exp=%h valid=%b busy=1 done=0",
                         use_b, k, o_data, o_sel, o_exp, o_valid, o_busy, o_done,
                         e.data, e.sel, e.exp, e.valid);
            end
            if (k == abort_k) begin
                drive(1'b0, 1'b1);
                @(negedge clk);
                drive(1'b0, 1'b0);
                model_lf[use_b] = e.lf;
                checks++;
                if ({o_data, o_sel, o_exp, o_valid, o_busy, o_done} !== '0) begin
                    errors++;
                    $display("FAIL abort_idle dut=%0d: data=%h sel=%0d exp=%h valid=%b busy=%b done=%b, want all 0",
                             use_b, o_data, o_sel, o_exp, o_valid, o_busy, o_done);
                end
                return;
            end
            drive(noise && (k == 0 || $urandom_range(0, 2) == 0), 1'b0);
            @(negedge clk);
        end
        model_lf[use_b] = q[q.size() - 1].lf;
        checks++;
        if ({o_data, o_sel, o_exp, o_valid, o_busy, o_done} !== {32'h0, 2'h0, 8'h0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL fin dut=%0d: data=%h sel=%0d exp=%h valid=%b busy=%b done=%b, want done=1 others 0",
                     use_b, o_data, o_sel, o_exp, o_valid, o_busy, o_done);
        end
        drive(noise, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({o_data, o_sel, o_exp, o_valid, o_busy, o_done} !== '0) begin
                errors++;
                $display("FAIL post_fin_idle dut=%0d i=%0d: busy=%b done=%b valid=%b data=%h, want all 0",
                         use_b, i, o_busy, o_done, o_valid, o_data);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({a_data, a_sel, a_exp, a_valid, a_busy, a_done, b_data, b_sel, b_exp, b_valid, b_busy, b_done} !== '0) begin
            errors++;
            $display("FAIL reset_initial: a=%h/%0d/%h b=%h/%0d/%h, want 0", a_data, a_sel, a_exp, b_data, b_sel, b_exp);
        end
        @(negedge clk);
        rst = 1'b0;
        model_lf[0] = 16'hACE1;
        model_lf[1] = 16'hACE1;
        pick(1'b0);
        drive(1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (a_busy !== 1'b1 || a_data !== 4'hE) begin
            errors++;
            $display("FAIL reset_prerun: busy=%b data=%h, want busy=1 data=e", a_busy, a_data);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a_data, a_sel, a_exp, a_valid, a_busy, a_done} !== '0) begin
            errors++;
            $display("FAIL reset_async: data=%h sel=%0d exp=%h valid=%b busy=%b done=%b, want all 0",
                     a_data, a_sel, a_exp, a_valid, a_busy, a_done);
        end
        @(negedge clk);
        rst = 1'b0;
        model_lf[0] = 16'hACE1;
        model_lf[1] = 16'hACE1;
    endtask

    task automatic test_default_sweep();
        bit exp_seq [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int vi;
        pick(1'b0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        run_sweep(-1, 1'b1);
        checks++;
        if (nbusy != NS * 40 || nvalid != NS * 4) begin
            errors++;
            $display("FAIL default_counts: busy=%0d valid=%0d, want busy=%0d valid=%0d", nbusy, nvalid, NS * 40, NS * 4);
        end
        vi = 0;
        for (int k = 0; k < cap_valid.size(); k++) begin
            if (cap_valid[k]) begin
                if (vi % NS < 4) begin
                    checks++;
                    if (cap_sel[k] !== 2'(vi / NS) || cap_exp[k] !== 8'(exp_seq[vi % NS])) begin
                        errors++;
                        $display("FAIL default_valid_seq n=%0d: sel=%0d exp=%0d, want sel=%0d exp=%0d",
                                 vi, cap_sel[k], cap_exp[k], vi / NS, exp_seq[vi % NS]);
                    end
                end
                vi++;
            end
        end
    endtask

    task automatic test_wide_sweep();
        int bad_sel;
        pick(1'b1);
        run_sweep(-1, 1'b1);
        checks++;
        if (nbusy != 3 * NS || nvalid != 3 * NS) begin
            errors++;
            $display("FAIL wide_counts: busy=%0d valid=%0d, want %0d each", nbusy, nvalid, 3 * NS);
        end
        checks++;
        if (cap_data[2 * NS + 2] !== 32'h0055AAAA || cap_exp[2 * NS + 2] !== 8'h55) begin
            errors++;
            $display("FAIL wide_ch2_s2: data=%h exp=%h, want data=55aaaa exp=55", cap_data[2 * NS + 2], cap_exp[2 * NS + 2]);
        end
        checks++;
        if (cap_data[0] !== 32'h00FFFF00 || cap_exp[0] !== 8'h00) begin
            errors++;
            $display("FAIL wide_ch0_s0: data=%h exp=%h, want data=ffff00 exp=00", cap_data[0], cap_exp[0]);
        end
        bad_sel = 0;
        foreach (cap_sel[k]) if (cap_sel[k] > 2'd2) bad_sel++;
        checks++;
        if (bad_sel != 0) begin
            errors++;
            $display("FAIL wide_sel_range: %0d cycles with sel=3, want 0", bad_sel);
        end
    endtask

    task automatic test_abort();
        pick(1'b0);
        run_sweep(36, 1'b0);
        checks++;
        if (a_busy !== 1'b0 || a_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold_idle: busy=%b done=%b, want 0 0", a_busy, a_done);
        end
        run_sweep(-1, 1'b0);
        run_sweep($urandom_range(0, NS * 40 - 1), 1'b1);
        pick(1'b1);
        run_sweep($urandom_range(0, NS * 3 - 1), 1'b0);
        run_sweep(-1, 1'b0);
    endtask

    task automatic test_start_rules();
        pick(1'b1);
        drive(1'b1, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({b_data, b_sel, b_exp, b_valid, b_busy, b_done} !== '0) begin
                errors++;
                $display("FAIL start_abort_idle i=%0d: busy=%b data=%h done=%b, want all 0", i, b_busy, b_data, b_done);
            end
            @(negedge clk);
        end
        run_sweep(-1, 1'b1);
    endtask

`ifdef MUX_STIM_RANDOM_EN
    task automatic test_random();
        logic [7:0] lane;
        pick(1'b0);
        run_sweep(-1, 1'b0);
        checks++;
        if (nbusy != 200 || nvalid != 20) begin
            errors++;
            $display("FAIL random_counts: busy=%0d valid=%0d, want 200 20", nbusy, nvalid);
        end
        checks++;
        if (cap_data[40] !== 32'h5 || cap_exp[40] !== 8'h1) begin
            errors++;
            $display("FAIL random_first_s4: data=%h exp=%h, want data=5 exp=1", cap_data[40], cap_exp[40]);
        end
        for (int k = 0; k < q.size(); k++) begin
            if (q[k].step == 4 && cap_valid[k]) begin
                lane = 8'((cap_data[k] >> cap_sel[k]) & 32'h1);
                checks++;
                if (cap_exp[k] !== lane) begin
                    errors++;
                    $display("FAIL random_exp_lane cyc=%0d: exp=%h, lane=%h", k, cap_exp[k], lane);
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef MUX_STIM_RANDOM_EN
        test_random();
`endif
        test_default_sweep();
        test_wide_sweep();
        test_abort();
        test_start_rules();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_stim_gen.md
Name: mux_stim_gen

Overview:
- Clocked, synthesizable stimulus generator for an N-to-1 multiplexer under test.
- Walks the select through every channel and drives a fixed set of data patterns on the selected lane and the other lanes.
- Publishes the expected mux output with a sample strobe, so a bench checker can compare it against the DUT output.
- Replaces the earlier fixed-timing, 4-channel, 1-bit initial-block generator, and adds handshaking and abort.

Parameters:
- WIDTH, 1: bits per data lane.
- CHANNELS, 4: number of mux inputs; must be >= 2.
- SEL_W, 2: select width; 2**SEL_W >= CHANNELS required.
- HOLD, 10: clock cycles per step; must be >= 1.
- SEED, 16'hACE1: LFSR seed; used only with MUX_STIM_RANDOM_EN.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  begin a sweep; sampled only in IDLE.
- Abort  in  1  synchronous; terminate the sweep.
- Data  out  CHANNELS*WIDTH  packed lanes, lane 0 at LSBs; drives the DUT data inputs.
- Sel  out  SEL_W  drives the DUT select.
- Expected  out  WIDTH  value the DUT output must equal while Valid=1.
- Valid  out  1  one-cycle sample strobe.
- Busy  out  1  sweep in progress.
- Done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE; Data, Sel, Expected, Valid, Busy, Done and all counters are 0.
- Definitions: PAT = WIDTH bits with bit i = 1 when i is even (WIDTH=8 gives 0x55). ~PAT is its bitwise complement. ONES = all ones.
- States: IDLE, RUN, FIN.
- IDLE:
  - All outputs 0.
  - Start=1 and Abort=0: next cycle enter RUN with channel c=0, step s=0, hold counter h=0.
- RUN, per channel c = 0..CHANNELS-1, in step order:
  - S0: Sel=c, lane c=0, other lanes=ONES, Expected=0.
  - S1: Sel=c, lane c=ONES, other lanes=0, Expected=ONES.
  - S2: Sel=c, lane c=PAT, other lanes=~PAT, Expected=PAT.
  - S3: Sel=c, lane c=~PAT, other lanes=PAT, Expected=~PAT.
- Step timing in RUN:
  - Each step lasts exactly HOLD cycles; Data, Sel and Expected are stable and registered for the whole step.
  - Valid=1 only in the last cycle of each step (h==HOLD-1). With HOLD=1, Valid is high every RUN cycle.
  - Busy=1 throughout RUN.
  - After S3 of channel CHANNELS-1, the next cycle enters FIN.
  - Total RUN length = 4*CHANNELS*HOLD cycles.
- FIN:
  - Lasts one cycle: Done=1, Busy=0, Data/Sel/Expected=0.
  - Returns to IDLE.
- Start rules:
  - Start is ignored in RUN.
  - Start asserted in the FIN cycle is not accepted; it must be asserted in IDLE.
- Abort:
  - In RUN: next cycle is IDLE with all outputs 0 and no Done; the sequence is not resumable.
  - Start and Abort together in IDLE: Abort wins, remain in IDLE.
- Sel never exceeds CHANNELS-1. Counters h, s and c wrap only through the step/channel advance rule above.

Optional Feature:
- Macro: MUX_STIM_RANDOM_EN.
- Defined:
  - Each channel gets a fifth step S4 after S3.
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; loaded with SEED on reset) advances once at the start of each S4.
  - Every lane is driven with LFSR[WIDTH-1:0] XOR (lane index), zero-extended as needed; Expected = lane c's value.
  - RUN length becomes 5*CHANNELS*HOLD.
- Undefined: no LFSR logic is present, the SEED parameter is unused, and there are 4 steps per channel.

Test Plan:
1. Reset: assert Reset mid-cycle with Clock idle -> all outputs 0 immediately, with no clock edge required.
2. Defaults (WIDTH=1, CHANNELS=4, HOLD=10), one-cycle Start:
   - Busy high for 160 cycles with 16 Valid pulses.
   - Sel sequence 0,0,0,0,1,...,3; Expected sequence 0,1,1,0 repeated.
   - Done high on cycle 161 only.
3. WIDTH=8, CHANNELS=3, HOLD=1:
   - Channel 2 S2 gives Data=0x55AAAA, Expected=0x55.
   - Channel 0 S0 gives Data=0xFFFF00, Expected=0x00.
   - Busy lasts 12 cycles; Sel never equals 3.
4. Abort at cycle 37 of the default run -> next cycle IDLE, outputs 0, no Done. A following Start restarts at Sel=0, step S0.
5. Start pulsed during Busy and in the FIN cycle -> both ignored. Start together with Abort in IDLE -> stays IDLE.
6. With MUX_STIM_RANDOM_EN, defaults:
   - Busy lasts 200 cycles with 20 Valid pulses.
   - The first S4 uses LFSR state one advance after 0xACE1.
   - Expected equals lane Sel on each S4 Valid.
